// File: rtl/lift_pkg.sv
`default_nettype none
// ============================================================================
// lift_pkg : shared state encoding and default sizes for the lift call scheduler
// Rev 1.0
// ============================================================================
package lift_pkg;

  localparam int DEF_NUM_FLOORS = 5;
  localparam int DEF_FLOOR_W    = 3;
  localparam int GROUND_FLOOR   = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_ARRIVE = 2'd2,
    ST_DWELL  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/lift_call_scheduler_if.sv
`default_nettype none
// ============================================================================
// lift_call_scheduler_if : call/feedback inputs and command/status outputs
// Rev 1.0
// ============================================================================
interface lift_call_scheduler_if import lift_pkg::*; #(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
) ();

  logic [NUM_FLOORS-1:0] call_req;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  up_signal;
  logic                  down_signal;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;
  logic                  dir_up;
  logic                  busy;
  logic                  fault;

  modport master (
    output call_req, current_floor,
    input  up_signal, down_signal, door_open, pending, dir_up, busy, fault
  );

  modport slave (
    input  call_req, current_floor,
    output up_signal, down_signal, door_open, pending, dir_up, busy, fault
  );

endinterface
`default_nettype wire

// File: rtl/lift_call_register.sv
`default_nettype none
// ============================================================================
// lift_call_register : pending-call bitmap with set/clear/absorb and
//                      above/below/here masks relative to the current floor
// Rev 1.0
// ============================================================================
module lift_call_register import lift_pkg::*; #(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic [NUM_FLOORS-1:0] call_req_i,
  input  wire logic [FLOOR_W-1:0]    floor_i,
  input  wire logic                  clear_i,
  input  wire logic                  absorb_i,
  output logic      [NUM_FLOORS-1:0] pending_o,
  output logic      [NUM_FLOORS-1:0] above_o,
  output logic      [NUM_FLOORS-1:0] below_o,
  output logic                       here_o
);

  logic [NUM_FLOORS-1:0] pending_q;
  logic [NUM_FLOORS-1:0] pending_d;
  logic [NUM_FLOORS-1:0] floor_hit;
  logic [NUM_FLOORS-1:0] clear_mask;
  logic [NUM_FLOORS-1:0] block_mask;

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_mask
    assign floor_hit[i] = (floor_i == FLOOR_W'(i));
    assign above_o[i]   = pending_q[i] && (FLOOR_W'(i) > floor_i);
    assign below_o[i]   = pending_q[i] && (FLOOR_W'(i) < floor_i);
  end

  // A clear beats a same-edge call; during dwell the current floor never re-arms.
  always_comb begin
    clear_mask = clear_i ? floor_hit : '0;
    block_mask = (clear_i || absorb_i) ? floor_hit : '0;
    pending_d  = (pending_q & ~clear_mask) | (call_req_i & ~block_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;
  assign here_o    = |(pending_q & floor_hit);

endmodule
`default_nettype wire

// File: rtl/lift_call_scheduler.sv
`default_nettype none
// ============================================================================
// lift_call_scheduler : collective-control call scheduler issuing single-step
//                       up/down commands to the lift, with dwell and homing
// Rev 1.0
// ============================================================================
module lift_call_scheduler import lift_pkg::*; #(
  parameter int NUM_FLOORS   = DEF_NUM_FLOORS,
  parameter int FLOOR_W      = DEF_FLOOR_W,
  parameter int DWELL_CYCLES = 3,
  parameter int IDLE_TIMEOUT = 5
) (
  input wire logic             clk,
  input wire logic             rst,
  lift_call_scheduler_if.slave bus
);

  localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 1);

  state_e              state_q;
  logic                dir_up_q;
  logic                homing_q;
  logic                fault_q;
  logic                up_q;
  logic                down_q;
  logic                door_q;
  logic                busy_q;
  logic [FLOOR_W-1:0]  expected_q;
  logic [DWELL_W-1:0]  dwell_cnt_q;
  logic [IDLE_W-1:0]   idle_cnt_q;

  logic [FLOOR_W-1:0]    floor;
  logic [NUM_FLOORS-1:0] pending;
  logic [NUM_FLOORS-1:0] above;
  logic [NUM_FLOORS-1:0] below;
  logic                  here;
  logic                  serve;
  logic                  absorb;
  logic [FLOOR_W-1:0]    up_tgt;
  logic [FLOOR_W-1:0]    dn_tgt;
  logic                  pick_up;
  logic                  resume_go;
  logic                  resume_dir;
  logic [IDLE_W-1:0]     idle_next;

  assign floor = bus.current_floor;

  lift_call_register #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_calls (
    .clk        (clk),
    .rst        (rst),
    .call_req_i (bus.call_req),
    .floor_i    (floor),
    .clear_i    (serve),
    .absorb_i   (absorb),
    .pending_o  (pending),
    .above_o    (above),
    .below_o    (below),
    .here_o     (here)
  );

  assign serve  = here && (((state_q == ST_IDLE) && !fault_q) ||
                           ((state_q == ST_ARRIVE) && (floor == expected_q)));
  assign absorb = (state_q == ST_DWELL);

  // Nearest call in each direction; an equal distance resolves upward.
  always_comb begin
    up_tgt = '0;
    dn_tgt = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (above[i]) up_tgt = FLOOR_W'(i);
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (below[i]) dn_tgt = FLOOR_W'(i);
    end
    pick_up    = (|above) && (!(|below) || ((up_tgt - floor) <= (floor - dn_tgt)));
    resume_go  = (|above) || (|below);
    resume_dir = dir_up_q ? (|above) : !(|below);
    idle_next  = (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT)) ? idle_cnt_q : idle_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dir_up_q    <= 1'b1;
      homing_q    <= 1'b0;
      fault_q     <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      door_q      <= 1'b0;
      busy_q      <= 1'b0;
      expected_q  <= '0;
      dwell_cnt_q <= '0;
      idle_cnt_q  <= '0;
    end else begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (fault_q) begin
            idle_cnt_q <= '0;
          end else if (here) begin
            state_q     <= ST_DWELL;
            door_q      <= 1'b1;
            busy_q      <= 1'b1;
            dwell_cnt_q <= '0;
            idle_cnt_q  <= '0;
          end else if ((|above) || (|below)) begin
            state_q    <= ST_MOVE;
            busy_q     <= 1'b1;
            dir_up_q   <= pick_up;
            up_q       <= pick_up;
            down_q     <= !pick_up;
            idle_cnt_q <= '0;
          end else if ((idle_next == IDLE_W'(IDLE_TIMEOUT)) &&
                       (floor != FLOOR_W'(GROUND_FLOOR))) begin
            state_q    <= ST_MOVE;
            busy_q     <= 1'b1;
            homing_q   <= 1'b1;
            dir_up_q   <= 1'b0;
            down_q     <= 1'b1;
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_next;
          end
        end
        ST_MOVE: begin
          expected_q <= dir_up_q ? floor + 1'b1 : floor - 1'b1;
          state_q    <= ST_ARRIVE;
        end
        ST_ARRIVE: begin
          if (floor != expected_q) begin
            fault_q <= 1'b1;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (here) begin
            homing_q    <= 1'b0;
            state_q     <= ST_DWELL;
            door_q      <= 1'b1;
            dwell_cnt_q <= '0;
          end else if (homing_q && !(|pending)) begin
            if (floor != FLOOR_W'(GROUND_FLOOR)) begin
              state_q  <= ST_MOVE;
              dir_up_q <= 1'b0;
              down_q   <= 1'b1;
            end else begin
              homing_q <= 1'b0;
              state_q  <= ST_IDLE;
              busy_q   <= 1'b0;
            end
          end else begin
            homing_q <= 1'b0;
            if (resume_go) begin
              state_q  <= ST_MOVE;
              dir_up_q <= resume_dir;
              up_q     <= resume_dir;
              down_q   <= !resume_dir;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_DWELL: begin
          if (dwell_cnt_q == DWELL_W'(DWELL_CYCLES - 1)) begin
            door_q <= 1'b0;
            if (resume_go) begin
              state_q  <= ST_MOVE;
              dir_up_q <= resume_dir;
              up_q     <= resume_dir;
              down_q   <= !resume_dir;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            dwell_cnt_q <= dwell_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.up_signal   = up_q;
  assign bus.down_signal = down_q;
  assign bus.door_open   = door_q;
  assign bus.pending     = pending;
  assign bus.dir_up      = dir_up_q;
  assign bus.busy        = busy_q;
  assign bus.fault       = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_lift_call_scheduler.sv
`default_nettype none
// ============================================================================
// tb_lift_call_scheduler : directed scenarios plus random calls, checked every
//                          cycle against a behavioural model of the scheduler
// Rev 1.0
// ============================================================================
module tb_lift_call_scheduler;

  localparam int NF = 5;
  localparam int FW = 3;
  localparam int DW = 3;
  localparam int IT = 5;

  localparam int M_IDLE   = 0;
  localparam int M_MOVE   = 1;
  localparam int M_ARRIVE = 2;
  localparam int M_DWELL  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lift_call_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

  lift_call_scheduler #(
    .NUM_FLOORS   (NF),
    .FLOOR_W      (FW),
    .DWELL_CYCLES (DW),
    .IDLE_TIMEOUT (IT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int floor_pos = 0;
  bit stuck = 1'b0;
  int ups, dns, doors;

  // reference model state
  int            m_mode, m_dwell, m_idle, m_exp;
  bit            m_dir, m_home, m_fault;
  bit [NF-1:0]   m_pend;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_pend = '0; m_dir = 1'b1; m_home = 1'b0;
    m_fault = 1'b0; m_idle = 0; m_dwell = 0; m_exp = 0;
  endtask

  // Pick the service continuation: keep going while calls lie ahead, otherwise turn around.
  task automatic model_resume(input int nu, input int nd);
    bit ahead, behind;
    ahead  = m_dir ? (nu >= 0) : (nd >= 0);
    behind = m_dir ? (nd >= 0) : (nu >= 0);
    if (ahead) m_mode = M_MOVE;
    else if (behind) begin m_dir = !m_dir; m_mode = M_MOVE; end
    else m_mode = M_IDLE;
  endtask

  task automatic model_step(input bit [NF-1:0] call, input int f);
    int nu, nd;
    bit here, clr, absorb;
    bit [NF-1:0] hit, cmask, bmask;
    nu = -1; nd = -1; hit = '0;
    for (int i = 0; i < NF; i++) begin
      if (m_pend[i] && i > f && nu < 0) nu = i;
      if (m_pend[i] && i < f) nd = i;
      if (i == f) hit[i] = 1'b1;
    end
    here   = |(m_pend & hit);
    absorb = (m_mode == M_DWELL);
    clr    = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (m_fault) begin
        end else if (here) begin
          clr = 1'b1; m_mode = M_DWELL; m_dwell = 0; m_idle = 0;
        end else if (nu >= 0 || nd >= 0) begin
          m_dir  = (nu >= 0) && (nd < 0 || (nu - f) <= (f - nd));
          m_mode = M_MOVE; m_idle = 0;
        end else begin
          m_idle = (m_idle + 1 > IT) ? IT : m_idle + 1;
          if (m_idle == IT && f != 0) begin
            m_home = 1'b1; m_dir = 1'b0; m_mode = M_MOVE; m_idle = 0;
          end
        end
      end
      M_MOVE: begin
        m_exp  = m_dir ? f + 1 : f - 1;
        m_mode = M_ARRIVE;
      end
      M_ARRIVE: begin
        if (f != m_exp) begin
          m_fault = 1'b1; m_mode = M_IDLE;
        end else if (here) begin
          clr = 1'b1; m_home = 1'b0; m_mode = M_DWELL; m_dwell = 0;
        end else if (m_home && m_pend == '0) begin
          if (f != 0) begin m_dir = 1'b0; m_mode = M_MOVE; end
          else begin m_home = 1'b0; m_mode = M_IDLE; end
        end else begin
          m_home = 1'b0;
          model_resume(nu, nd);
        end
      end
      default: begin
        if (m_dwell == DW - 1) model_resume(nu, nd);
        else m_dwell++;
      end
    endcase
    cmask  = clr ? hit : '0;
    bmask  = (clr || absorb) ? hit : '0;
    m_pend = (m_pend & ~cmask) | (call & ~bmask);
  endtask

  task automatic compare_all();
    check_eq("up_signal",   bus.up_signal,   (m_mode == M_MOVE) && m_dir);
    check_eq("down_signal", bus.down_signal, (m_mode == M_MOVE) && !m_dir);
    check_eq("door_open",   bus.door_open,   m_mode == M_DWELL);
    check_eq("pending",     bus.pending,     m_pend);
    check_eq("dir_up",      bus.dir_up,      m_dir);
    check_eq("busy",        bus.busy,        m_mode != M_IDLE);
    check_eq("fault",       bus.fault,       m_fault);
  endtask

  // One clock: drive at negedge, lift and model advance at posedge, compare at next negedge.
  task automatic tick(input bit [NF-1:0] call, input bit do_rst);
    bit pu, pd;
    int f;
    bus.call_req = call;
    rst = do_rst;
    pu = bus.up_signal; pd = bus.down_signal; f = floor_pos;
    @(posedge clk);
    if (do_rst) model_reset();
    else model_step(call, f);
    if (!stuck) begin
      if (pu && floor_pos < NF - 1) floor_pos++;
      if (pd && floor_pos > 0) floor_pos--;
    end
    #1;
    bus.current_floor = FW'(floor_pos);
    @(negedge clk);
    compare_all();
    if (bus.up_signal) ups++;
    if (bus.down_signal) dns++;
    if (bus.door_open) doors++;
  endtask

  task automatic clear_counts();
    ups = 0; dns = 0; doors = 0;
  endtask

  task automatic run_until_idle(input int max_cyc);
    int c;
    c = 0;
    while ((bus.busy || bus.pending != '0) && c < max_cyc) begin
      tick('0, 1'b0);
      c++;
    end
    check_eq("settle_busy", bus.busy, 1'b0);
  endtask

  initial begin
    int n;
    bus.call_req = '0;
    bus.current_floor = '0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    tick('0, 1'b1);
    tick('0, 1'b1);
    check_eq("rst_dir", bus.dir_up, 1'b1);
    check_eq("rst_pending", bus.pending, 0);

    // single call two floors up
    clear_counts();
    tick(5'b00100, 1'b0);
    run_until_idle(40);
    check_eq("t1_ups", ups, 2);
    check_eq("t1_doors", doors, DW);
    check_eq("t1_floor", floor_pos, 2);

    // adjacent call latency
    clear_counts();
    tick(5'b01000, 1'b0);
    n = 1;
    while (!bus.door_open && n < 20) begin tick('0, 1'b0); n++; end
    check_eq("latency", n, 4);
    run_until_idle(40);

    // homing from floor 3
    clear_counts();
    for (int i = 0; i < 30; i++) tick('0, 1'b0);
    check_eq("home_downs", dns, 3);
    check_eq("home_floor", floor_pos, 0);

    // nearest first: lift at 2, calls at 1 and 4
    tick(5'b00100, 1'b0);
    run_until_idle(40);
    tick(5'b10010, 1'b0);
    n = 0;
    while (!bus.up_signal && !bus.down_signal && n < 20) begin tick('0, 1'b0); n++; end
    check_eq("nearest_down", bus.down_signal, 1'b1);
    run_until_idle(80);

    // call during homing aborts it: go to 3, wait for homing step, call 2
    tick(5'b01000, 1'b0);
    run_until_idle(60);
    n = 0;
    while (!bus.down_signal && n < 30) begin tick('0, 1'b0); n++; end
    clear_counts();
    tick(5'b00100, 1'b0);
    run_until_idle(40);
    check_eq("abort_floor", floor_pos, 2);
    check_eq("abort_doors", doors, DW);

    // own-floor call during dwell is absorbed
    clear_counts();
    tick(5'b10000, 1'b0);
    n = 0;
    while (!bus.door_open && n < 20) begin tick('0, 1'b0); n++; end
    tick(5'b10000, 1'b0);
    check_eq("absorb_pend", bus.pending, 0);
    run_until_idle(40);
    check_eq("absorb_doors", doors, DW);

    // stuck lift raises fault, then rst clears it
    tick(5'b00001, 1'b0);
    n = 0;
    while (!bus.down_signal && n < 20) begin tick('0, 1'b0); n++; end
    stuck = 1'b1;
    tick('0, 1'b0);
    tick('0, 1'b0);
    check_eq("fault_set", bus.fault, 1'b1);
    clear_counts();
    for (int i = 0; i < 10; i++) tick(5'b00010, 1'b0);
    check_eq("fault_steps", ups + dns, 0);
    stuck = 1'b0;
    tick('0, 1'b1);
    check_eq("fault_clr", bus.fault, 1'b0);
    check_eq("fault_pend", bus.pending, 0);

    // random calls and occasional reset
    for (int i = 0; i < 4000; i++) begin
      logic [NF-1:0] c;
      c = ($urandom_range(0, 7) == 0) ? NF'($urandom) : '0;
      tick(c, $urandom_range(0, 599) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
